// File: rtl/seven_segment_mux_counter.sv
// Prescaled up/down BCD counter with a time-multiplexed seven-segment display.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shows).
module seven_segment_mux_counter #(
    parameter int          DIGITS          = 4,
    parameter int          COMPARE_W       = 24,
    parameter int          SCAN_W          = 10,
    parameter logic [23:0] DEFAULT_COMPARE = 24'd1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [COMPARE_W-1:0]  compare_in,
    input  logic                  update_compare,
    input  logic                  enable,
    input  logic                  count_down,
    input  logic                  clear,
    output logic [6:0]            led_out,
    output logic [DIGITS-1:0]     digit_sel,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  tick
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [COMPARE_W-1:0] RST_CMP = COMPARE_W'(DEFAULT_COMPARE);

    logic [COMPARE_W-1:0] r_prescaler;
    logic [COMPARE_W-1:0] r_compare;
    logic                 r_upd_q;
    logic [4*DIGITS-1:0]  r_count;
    logic                 r_tick;
    logic [SCAN_W-1:0]    r_scan;
    logic [IDX_W-1:0]     r_idx;
    logic [DIGITS-1:0]    r_sel;
    logic [6:0]           r_led;

    logic [4*DIGITS-1:0]  w_next;
    logic                 w_carry;
    logic [3:0]           w_nib;
    logic [IDX_W-1:0]     w_idx_next;
    logic [3:0]           w_digit;
    logic                 w_hi_zero;
    logic [6:0]           w_seg;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    // Ripple carry/borrow through the digits, starting at digit 0.
    always_comb begin
        w_next  = r_count;
        w_carry = 1'b1;
        w_nib   = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            w_nib = r_count[i*4 +: 4];
            if (w_carry) begin
                if (!count_down) begin
                    if (w_nib == 4'd9) begin
                        w_next[i*4 +: 4] = 4'd0;
                    end else begin
                        w_next[i*4 +: 4] = w_nib + 4'd1;
                        w_carry          = 1'b0;
                    end
                end else begin
                    if (w_nib == 4'd0) begin
                        w_next[i*4 +: 4] = 4'd9;
                    end else begin
                        w_next[i*4 +: 4] = w_nib - 4'd1;
                        w_carry          = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_upd_q   <= 1'b0;
            r_compare <= RST_CMP;
        end else begin
            r_upd_q <= update_compare;
            if (update_compare && !r_upd_q) begin
                r_compare <= compare_in;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prescaler <= '0;
            r_count     <= '0;
            r_tick      <= 1'b0;
        end else if (clear) begin
            r_prescaler <= '0;
            r_count     <= '0;
            r_tick      <= 1'b0;
        end else if (enable) begin
            if (r_prescaler >= r_compare) begin
                r_prescaler <= '0;
                r_tick      <= 1'b1;
                r_count     <= w_next;
            end else begin
                r_prescaler <= r_prescaler + COMPARE_W'(1);
                r_tick      <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    // Segments and enable are built from the upcoming index so they switch together.
    always_comb begin
        w_idx_next = r_idx;
        if (&r_scan) begin
            w_idx_next = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end
        w_digit   = 4'd0;
        w_hi_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == w_idx_next) begin
                w_digit = r_count[i*4 +: 4];
            end
            if (IDX_W'(i) >= w_idx_next && r_count[i*4 +: 4] != 4'd0) begin
                w_hi_zero = 1'b0;
            end
        end
`ifdef LEADING_ZERO_BLANK_EN
        w_seg = (w_idx_next != '0 && w_hi_zero) ? 7'h00 : seg7(w_digit);
`else
        w_seg = seg7(w_digit);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scan <= '0;
            r_idx  <= '0;
            r_sel  <= DIGITS'(1);
            r_led  <= 7'b0111111;
        end else begin
            r_scan <= r_scan + SCAN_W'(1);
            r_idx  <= w_idx_next;
            r_sel  <= DIGITS'(1) << w_idx_next;
            r_led  <= w_seg;
        end
    end

    assign led_out   = r_led;
    assign digit_sel = r_sel;
    assign count_bcd = r_count;
    assign tick      = r_tick;

endmodule

// File: tb/tb_seven_segment_mux_counter.sv
// Scoreboard bench: stimulus queues expected counts per tick, a monitor pops on each tick.
// Small SCAN_W keeps scan checks short.
module tb_seven_segment_mux_counter;

    localparam int DIGITS    = 4;
    localparam int COMPARE_W = 24;
    localparam int SCAN_W    = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [COMPARE_W-1:0] compare_in = '0;
    logic                 update_compare = 1'b0;
    logic                 enable = 1'b0;
    logic                 count_down = 1'b0;
    logic                 clear = 1'b0;
    logic [6:0]           led_out;
    logic [DIGITS-1:0]    digit_sel;
    logic [4*DIGITS-1:0]  count_bcd;
    logic                 tick;

    seven_segment_mux_counter #(
        .DIGITS(DIGITS),
        .COMPARE_W(COMPARE_W),
        .SCAN_W(SCAN_W),
        .DEFAULT_COMPARE(24'd1000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .compare_in(compare_in),
        .update_compare(update_compare),
        .enable(enable),
        .count_down(count_down),
        .clear(clear),
        .led_out(led_out),
        .digit_sel(digit_sel),
        .count_bcd(count_bcd),
        .tick(tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        int          gap;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   last_tick = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        int m;
        m = ((v % 10000) + 10000) % 10000;
        return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    task automatic push(input int v, input int gap);
        exp_t e;
        e.val = to_bcd(v);
        e.gap = gap;
        q.push_back(e);
    endtask

    // Monitor: every tick must match the front of the scoreboard.
    always @(negedge clk) begin
        if (!reset && tick) begin
            if (q.size() == 0) begin
                chk("sb_unexpected_tick", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_count", 32'(count_bcd), 32'(e.val));
                if (e.gap != 0) chk("sb_tick_gap", 32'(cyc - last_tick), 32'(e.gap));
            end
            last_tick = cyc;
        end
    end

    task automatic load_cmp(input int c);
        @(negedge clk);
        update_compare = 1'b0;
        compare_in = COMPARE_W'(c);
        @(negedge clk);
        update_compare = 1'b1;
        @(negedge clk);
        update_compare = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic run(input int n);
        @(negedge clk);
        enable = 1'b1;
        repeat (n) @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic drain(input string name);
        @(negedge clk);
        chk(name, 32'(q.size()), 32'd0);
        q.delete();
    endtask

    task automatic wait_digit(input int d);
        int k;
        k = 0;
        while (digit_sel !== DIGITS'(1 << d) && k < 4 * (1 << SCAN_W) + 4) begin
            @(negedge clk);
            k++;
        end
        chk("wait_digit_sel", 32'(digit_sel), 32'(1 << d));
    endtask

    logic [6:0] exp_led [4];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and first scan advance
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_led", 32'(led_out), 32'h3F);
        chk("rst_sel", 32'(digit_sel), 32'h1);
        chk("rst_count", 32'(count_bcd), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        repeat (15) @(negedge clk);
        chk("scan_hold", 32'(digit_sel), 32'h1);
        @(negedge clk);
        chk("scan_adv", 32'(digit_sel), 32'h2);
`ifdef LEADING_ZERO_BLANK_EN
        chk("scan_led1", 32'(led_out), 32'h00);
`else
        chk("scan_led1", 32'(led_out), 32'h3F);
`endif

        // Compare load, period 5, held level does not reload
        @(negedge clk);
        compare_in = 24'd4;
        update_compare = 1'b1;
        @(negedge clk);
        compare_in = 24'd1;
        do_clear();
        for (int k = 1; k <= 20; k++) push(k, (k == 1) ? 0 : 5);
        run(100);
        update_compare = 1'b0;
        drain("drain_period5");

        // Up-count through 10000 ticks with compare 0
        load_cmp(0);
        do_clear();
        for (int k = 1; k <= 10000; k++) push(k, (k == 1) ? 0 : 1);
        run(10000);
        drain("drain_up_wrap");
        chk("up_wrap_zero", 32'(count_bcd), 32'h0000);

        // Down-count borrow from 0100 through 0000 to 9999
        for (int k = 1; k <= 100; k++) push(k, (k == 1) ? 0 : 1);
        run(100);
        drain("drain_to_100");
        chk("at_0100", 32'(count_bcd), 32'h0100);
        count_down = 1'b1;
        for (int k = 1; k <= 101; k++) push(100 - k, (k == 1) ? 0 : 1);
        run(101);
        drain("drain_down");
        chk("down_wrap", 32'(count_bcd), 32'h9999);
        count_down = 1'b0;

        // Clear wins over a coincident tick; compare stays 4
        load_cmp(4);
        do_clear();
        chk("clear_count", 32'(count_bcd), 32'h0);
        @(negedge clk);
        enable = 1'b1;
        repeat (4) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        enable = 1'b0;
        chk("clr_prio_count", 32'(count_bcd), 32'h0);
        chk("clr_prio_tick", 32'(tick), 32'h0);
        push(1, 0);
        run(5);
        drain("drain_cmp_kept");

        // Compare lowered below the running prescaler
        load_cmp(60);
        do_clear();
        run(50);
        load_cmp(10);
        push(1, 0);
        run(1);
        drain("drain_cmp_lowered");

        // Count to 0042 and check the displayed glyphs per digit
        load_cmp(0);
        do_clear();
        for (int k = 1; k <= 42; k++) push(k, (k == 1) ? 0 : 1);
        run(42);
        drain("drain_42");
        chk("count_0042", 32'(count_bcd), 32'h0042);
        exp_led[0] = 7'h5B;
        exp_led[1] = 7'h66;
`ifdef LEADING_ZERO_BLANK_EN
        exp_led[2] = 7'h00;
        exp_led[3] = 7'h00;
`else
        exp_led[2] = 7'h3F;
        exp_led[3] = 7'h3F;
`endif
        for (int d = 0; d < 4; d++) begin
            wait_digit(d);
            chk("led_digit", 32'(led_out), 32'(exp_led[d]));
        end

        // Asynchronous reset between edges
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_led", 32'(led_out), 32'h3F);
        chk("async_sel", 32'(digit_sel), 32'h1);
        chk("async_count", 32'(count_bcd), 32'h0);
        chk("async_tick", 32'(tick), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
